// File: rtl/riscv_inst_encoder_pkg.sv
// Purpose: shared types and RV32I encoding constants for the instruction encoder.
// Contents: request opcode enum, error-code enum, FSM state enum,
//           encode-result struct, opcode/funct3/funct7 constants.
package riscv_inst_encoder_pkg;

  typedef enum logic [2:0] {
    ENC_ADD  = 3'd0,
    ENC_ADDI = 3'd1,
    ENC_LW   = 3'd2,
    ENC_SW   = 3'd3,
    ENC_JAL  = 3'd4,
    ENC_BEQ  = 3'd5,
    ENC_END  = 3'd6
  } enc_op_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OP   = 2'd1,
    ERR_IMM  = 2'd2,
    ERR_WRAP = 2'd3
  } enc_err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  // Result of encoding one request: classification flags plus the packed word
  typedef struct packed {
    logic        bad_op;
    logic        bad_imm;
    logic        is_end;
    logic [31:0] word;
  } enc_result_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [6:0] F7_ADD  = 7'b0000000;

endpackage

// File: rtl/riscv_enc_fifo.sv
// Purpose: small synchronous FIFO buffering encoded words ahead of imem.
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata (head word),
//        full, empty. Push when full and pop when empty are ignored.
module riscv_enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rdata   = mem[rd_ptr[PW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage needs no reset; contents are only visible while non-empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/riscv_inst_encoder.sv
// Purpose: packs field-level instruction requests into RV32I words and streams
//          them into imem at consecutive word addresses.
// Ports: start_i begins a load; in_valid/in_ready + in_op/rd/rs1/rs2/imm request;
//        imem_wen/imem_ready/imem_addr/imem_wdata write port; done_o, err_o,
//        err_code (first error wins), count_o (words written since start).
module riscv_inst_encoder
  import riscv_inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  enc_op_e           in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_wen,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done_o,
  output logic              err_o,
  output enc_err_e          err_code,
  output logic [ADDR_W-1:0] count_o
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  // Encode one request and range-check its immediate
  function automatic enc_result_t encode(input enc_op_e op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] imm);
    enc_result_t r;
    logic i_ok, b_ok, j_ok;
    r    = '0;
    // Sign-extension test: all bits above the field's sign bit equal it
    i_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
    b_ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
    j_ok = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
    case (op)
      ENC_ADD:  r.word = {F7_ADD, rs2, rs1, F3_ADD, rd, OPC_OP};
      ENC_ADDI: begin
        r.word    = {imm[11:0], rs1, F3_ADDI, rd, OPC_OP_IMM};
        r.bad_imm = !i_ok;
      end
      ENC_LW: begin
        r.word    = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
        r.bad_imm = !i_ok;
      end
      ENC_SW: begin
        r.word    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
        r.bad_imm = !i_ok;
      end
      ENC_BEQ: begin
        r.word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
        r.bad_imm = !b_ok;
      end
      ENC_JAL: begin
        r.word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        r.bad_imm = !j_ok;
      end
      ENC_END: r.is_end = 1'b1;
      default: r.bad_op = 1'b1;
    endcase
    return r;
  endfunction

  enc_state_e  state;
  enc_result_t enc;
  logic [31:0] head;
  logic        full;
  logic        empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic        active;

  assign enc        = encode(in_op, in_rd, in_rs1, in_rs2, in_imm);
  assign in_ready   = (state == ST_RUN) && !full;
  assign accept     = in_valid && in_ready;
  assign push       = accept && !enc.bad_op && !enc.bad_imm && !enc.is_end;
  assign active     = (state == ST_RUN) || (state == ST_DRAIN);
  assign imem_wen   = active && !empty;
  assign pop        = imem_wen && imem_ready;
  // Stale buffer contents are hidden when no write is requested
  assign imem_wdata = imem_wen ? head : '0;

  riscv_enc_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (enc.word),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Control FSM with address, count and error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      imem_addr <= BASE;
      count_o   <= '0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      err_code  <= ERR_NONE;
    end else if ((state == ST_IDLE || state == ST_DONE) && start_i) begin
      state     <= ST_RUN;
      imem_addr <= BASE;
      count_o   <= '0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      if (pop) begin
        imem_addr <= imem_addr + ADDR_W'(1);
        count_o   <= count_o + ADDR_W'(1);
      end
      // Request errors take precedence over a same-cycle wrap
      if (!err_o && accept && (enc.bad_op || enc.bad_imm)) begin
        err_o    <= 1'b1;
        err_code <= enc.bad_op ? ERR_OP : ERR_IMM;
      end else if (!err_o && pop && (imem_addr == '1)) begin
        err_o    <= 1'b1;
        err_code <= ERR_WRAP;
      end
      case (state)
        ST_RUN:   if (accept && enc.is_end) state <= ST_DRAIN;
        ST_DRAIN: if (empty) begin
          state  <= ST_DONE;
          done_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_inst_encoder.sv
// Purpose: directed self-checking bench for riscv_inst_encoder (default
//          instance plus an ADDR_W=2 instance for address wrap).
module tb_riscv_inst_encoder;
  import riscv_inst_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        in_valid = 1'b0;
  logic        imem_ready = 1'b0;
  enc_op_e     in_op = ENC_ADD;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;

  logic        in_ready, imem_wen, done_o, err_o;
  logic [9:0]  imem_addr, count_o;
  logic [31:0] imem_wdata;
  enc_err_e    err_code;

  logic        in_ready2, imem_wen2, done2, err2;
  logic [1:0]  imem_addr2, count2;
  logic [31:0] imem_wdata2;
  enc_err_e    err_code2;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  logic [31:0] wa2[$];

  always #5 clk = ~clk;

  riscv_inst_encoder #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_wen(imem_wen), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .done_o(done_o), .err_o(err_o), .err_code(err_code),
    .count_o(count_o)
  );

  riscv_inst_encoder #(.ADDR_W(2), .BASE_ADDR(0), .DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_wen(imem_wen2), .imem_ready(imem_ready), .imem_addr(imem_addr2),
    .imem_wdata(imem_wdata2), .done_o(done2), .err_o(err2), .err_code(err_code2),
    .count_o(count2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Write log: a write is pending at negedge and fires on the next posedge
  always @(negedge clk) begin
    if (imem_wen && imem_ready) begin
      wa.push_back(32'(imem_addr));
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
    end
    if (imem_wen2 && imem_ready) wa2.push_back(32'(imem_addr2));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start2 = 1'b1;
    else     start  = 1'b1;
    tick(1);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic send(input bit sel, input enc_op_e op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(sel ? in_ready2 : in_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 40), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int n;
    n = 0;
    @(negedge clk);
    while (!(sel ? done2 : done_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(sel ? done2 : done_o), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); wa2.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] exp1 [6];
    logic [31:0] exp2 [6];
    logic [31:0] exp4 [5];
    exp1 = '{32'h00500093, 32'h002081B3, 32'h0020A423, 32'h0080A183, 32'hFE208EE3, 32'h008000EF};
    exp2 = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093, 32'h00500093, 32'h00600093};
    exp4 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

    // Reset state
    tick(2);
    check("rst_wen", 32'(imem_wen), 0);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_count", 32'(count_o), 0);
    rst_n = 1'b1;
    tick(1);

    // Program load with imem always ready
    imem_ready = 1'b1;
    clear_log();
    pulse_start(0);
    send(0, ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    send(0, ENC_ADD,  5'd3, 5'd1, 5'd2, 32'd0);
    send(0, ENC_SW,   5'd0, 5'd1, 5'd2, 32'd8);
    send(0, ENC_LW,   5'd3, 5'd1, 5'd0, 32'd8);
    send(0, ENC_BEQ,  5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    send(0, ENC_JAL,  5'd1, 5'd0, 5'd0, 32'd8);
    send(0, ENC_END,  5'd0, 5'd0, 5'd0, 32'd0);
    wait_done(0);
    check("load_nwrites", 32'(wa.size()), 6);
    for (int i = 0; i < 6; i++) begin
      check("load_addr", (i < wa.size()) ? wa[i] : 32'hDEADBEEF, 32'(i));
      check("load_data", (i < wd.size()) ? wd[i] : 32'hDEADBEEF, exp1[i]);
    end
    check("load_count", 32'(count_o), 6);
    check("load_err", 32'(err_o), 0);

    // Backpressure: buffer fills at 4, then drains back-to-back
    imem_ready = 1'b0;
    clear_log();
    pulse_start(0);
    for (int k = 1; k <= 4; k++) send(0, ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'(k));
    in_op = ENC_ADDI; in_rd = 5'd1; in_rs1 = 5'd0; in_imm = 32'd5; in_valid = 1'b1;
    @(negedge clk);
    check("full_ready", 32'(in_ready), 0);
    check("full_nowrite", 32'(wa.size()), 0);
    @(posedge clk);
    #1;
    check("full_ready2", 32'(in_ready), 0);
    imem_ready = 1'b1;
    send(0, ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    send(0, ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'd6);
    send(0, ENC_END,  5'd0, 5'd0, 5'd0, 32'd0);
    wait_done(0);
    check("bp_nwrites", 32'(wa.size()), 6);
    for (int i = 0; i < 6; i++) begin
      check("bp_addr", (i < wa.size()) ? wa[i] : 32'hDEADBEEF, 32'(i));
      check("bp_data", (i < wd.size()) ? wd[i] : 32'hDEADBEEF, exp2[i]);
    end
    check("bp_b2b_1", (wc.size() > 3) ? 32'(wc[1] - wc[0]) : 32'hDEADBEEF, 1);
    check("bp_b2b_3", (wc.size() > 3) ? 32'(wc[3] - wc[0]) : 32'hDEADBEEF, 3);
    check("bp_count", 32'(count_o), 6);

    // Immediate errors: first error wins, nothing written
    clear_log();
    pulse_start(0);
    send(0, ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048);
    send(0, ENC_BEQ,  5'd0, 5'd1, 5'd2, 32'd3);
    tick(1);
    check("imm_code", 32'(err_code), 32'(ERR_IMM));
    check("imm_err", 32'(err_o), 1);
    check("imm_count", 32'(count_o), 0);
    check("imm_nowrite", 32'(wa.size()), 0);
    send(0, enc_op_e'(3'd7), 5'd0, 5'd0, 5'd0, 32'd0);
    tick(1);
    check("first_wins", 32'(err_code), 32'(ERR_IMM));
    send(0, ENC_END, 5'd0, 5'd0, 5'd0, 32'd0);
    wait_done(0);
    pulse_start(0);
    check("clr_err", 32'(err_o), 0);
    check("clr_code", 32'(err_code), 32'(ERR_NONE));
    check("clr_done", 32'(done_o), 0);
    // Lowest legal I-immediate, then an illegal opcode
    send(0, ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFFF800);
    tick(2);
    check("imm_min_err", 32'(err_o), 0);
    check("imm_min_data", (wd.size() > 0) ? wd[0] : 32'hDEADBEEF, 32'h80000093);
    send(0, enc_op_e'(3'd7), 5'd0, 5'd0, 5'd0, 32'd0);
    tick(1);
    check("op_code", 32'(err_code), 32'(ERR_OP));
    send(0, ENC_JAL, 5'd1, 5'd0, 5'd0, 32'd1);
    send(0, ENC_END, 5'd0, 5'd0, 5'd0, 32'd0);
    wait_done(0);
    check("op_count", 32'(count_o), 1);
    check("op_code_kept", 32'(err_code), 32'(ERR_OP));

    // Address wrap on the 2-bit instance
    clear_log();
    pulse_start(1);
    for (int k = 1; k <= 5; k++) send(1, ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'(k));
    send(1, ENC_END, 5'd0, 5'd0, 5'd0, 32'd0);
    wait_done(1);
    check("wrap_nwrites", 32'(wa2.size()), 5);
    for (int i = 0; i < 5; i++)
      check("wrap_addr", (i < wa2.size()) ? wa2[i] : 32'hDEADBEEF, exp4[i]);
    check("wrap_code", 32'(err_code2), 32'(ERR_WRAP));
    check("wrap_err", 32'(err2), 1);
    check("wrap_count", 32'(count2), 1);

    // Reset while draining with three words buffered
    imem_ready = 1'b0;
    clear_log();
    pulse_start(0);
    for (int k = 1; k <= 3; k++) send(0, ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'(k));
    send(0, ENC_END, 5'd0, 5'd0, 5'd0, 32'd0);
    tick(1);
    check("drain_wen", 32'(imem_wen), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wen", 32'(imem_wen), 0);
    imem_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("rst_mid_nowrite", 32'(wa.size()), 0);
    check("rst_mid_done", 32'(done_o), 0);
    check("rst_mid_ready", 32'(in_ready), 0);
    check("rst_mid_addr", 32'(imem_addr), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
